// File: rtl/sreg_pkg.sv
// Shared types and helpers for the serial-to-parallel deserializer.
package sreg_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ACCUM = 2'd1,
    FULL  = 2'd2
  } sreg_state_e;

  // Bits needed to hold a bit count from 0 up to and including width.
  function automatic int count_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sreg_core.sv
// Shift register with synchronous clear and parallel load.
// Priority: clr, then load, then shift.
module sreg_core
  import sreg_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             en,
  input  logic             sin,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Register update: clear wins over load, load wins over a shift.
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (en) begin
      if (MSB_FIRST) q <= {q[WIDTH-2:0], sin};
      else           q <= {sin, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/sreg_deser.sv
// Serial-to-parallel deserializer with a one-word output slot.
//
//  state | meaning
//  EMPTY | no bits held, accepting
//  ACCUM | 0 < count < WIDTH, accepting
//  FULL  | complete word parked in q, waiting for the output slot
module sreg_deser
  import sreg_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset_b,
  input  logic                      sin,
  input  logic                      sin_valid,
  output logic                      sin_ready,
  input  logic                      flush,
  output logic [WIDTH-1:0]          q,
  output logic [WIDTH-1:0]          pdata,
  output logic                      pvalid,
  input  logic                      pready,
  output logic [count_w(WIDTH)-1:0] count
);

  localparam int CW = count_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  sreg_state_e      state_q, state_d;
  logic [CW-1:0]    count_d;
  logic [WIDTH-1:0] pdata_d;
  logic             pvalid_d;
  logic             core_en, core_clr;
  logic             accept, slot_free;
  logic [WIDTH-1:0] shifted;

  // Word the register will hold after accepting sin this cycle.
  assign shifted = MSB_FIRST ? {q[WIDTH-2:0], sin} : {sin, q[WIDTH-1:1]};

  // Parallel load is not needed here; the register is only shifted or cleared.
  sreg_core #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_core (
    .clk (clk),
    .en  (core_en),
    .sin (sin),
    .clr (core_clr),
    .load(1'b0),
    .d   ({WIDTH{1'b0}}),
    .q   (q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_b) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  // Next state, counter, output slot and register controls.
  always_comb begin
    state_d   = state_q;
    count_d   = count;
    pdata_d   = pdata;
    pvalid_d  = pvalid && !pready;
    core_en   = 1'b0;
    core_clr  = !reset_b;
    sin_ready = (state_q != FULL);
    accept    = sin_valid && sin_ready;
    slot_free = !pvalid || pready;

    if (flush) begin
      // Abort wins over any same-cycle accept or pending transfer.
      state_d  = EMPTY;
      count_d  = '0;
      core_clr = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY, ACCUM: begin
          if (accept) begin
            core_en = 1'b1;
            if (count == CNT_LAST) begin
              if (slot_free) begin
                pdata_d  = shifted;
                pvalid_d = 1'b1;
                count_d  = '0;
                state_d  = EMPTY;
              end else begin
                count_d = CNT_FULL;
                state_d = FULL;
              end
            end else begin
              count_d = count + CW'(1);
              state_d = ACCUM;
            end
          end
        end
        FULL: begin
          if (slot_free) begin
            pdata_d  = q;
            pvalid_d = 1'b1;
            count_d  = '0;
            state_d  = EMPTY;
            core_clr = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Counter and output slot registers.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      count  <= '0;
      pdata  <= '0;
      pvalid <= 1'b0;
    end else begin
      count  <= count_d;
      pdata  <= pdata_d;
      pvalid <= pvalid_d;
    end
  end

endmodule

// File: tb/tb_sreg_deser.sv
// Self-checking bench: directed table at WIDTH=8 (both bit orders), hand
// sequences for FULL-flush and reset, random streams at WIDTH=5 and 13.
module tb_sreg_deser;

  logic clk = 1'b0;
  logic reset_b;
  logic sin, sin_valid, flush, pready;
  logic rsin, rvalid, rflush, rpready;

  logic       a_ready, a_pvalid, b_ready, b_pvalid;
  logic [7:0] a_q, a_pdata, b_q, b_pdata;
  logic [3:0] a_count, b_count;

  logic        c_ready, c_pvalid, d_ready, d_pvalid;
  logic [4:0]  c_q, c_pdata;
  logic [2:0]  c_count;
  logic [12:0] d_q, d_pdata;
  logic [3:0]  d_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sreg_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .reset_b(reset_b), .sin(sin), .sin_valid(sin_valid),
    .sin_ready(a_ready), .flush(flush), .q(a_q), .pdata(a_pdata),
    .pvalid(a_pvalid), .pready(pready), .count(a_count));

  sreg_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .reset_b(reset_b), .sin(sin), .sin_valid(sin_valid),
    .sin_ready(b_ready), .flush(flush), .q(b_q), .pdata(b_pdata),
    .pvalid(b_pvalid), .pready(pready), .count(b_count));

  sreg_deser #(.WIDTH(5), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .reset_b(reset_b), .sin(rsin), .sin_valid(rvalid),
    .sin_ready(c_ready), .flush(rflush), .q(c_q), .pdata(c_pdata),
    .pvalid(c_pvalid), .pready(rpready), .count(c_count));

  sreg_deser #(.WIDTH(13), .MSB_FIRST(1'b0)) u_d (
    .clk(clk), .reset_b(reset_b), .sin(rsin), .sin_valid(rvalid),
    .sin_ready(d_ready), .flush(rflush), .q(d_q), .pdata(d_pdata),
    .pvalid(d_pvalid), .pready(rpready), .count(d_count));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       sin, vld, fl, pr;
    logic       exp_pv;
    logic [7:0] exp_pd;
    int         exp_cnt;
    logic       exp_rdy;
    logic       chk_q;
    logic [7:0] exp_q;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic s, input logic v, input logic f, input logic p,
                     input logic pv, input logic [7:0] pd, input int cnt,
                     input logic rdy, input logic cq, input logic [7:0] eq);
    vec_t r;
    r.sin = s; r.vld = v; r.fl = f; r.pr = p;
    r.exp_pv = pv; r.exp_pd = pd; r.exp_cnt = cnt; r.exp_rdy = rdy;
    r.chk_q = cq; r.exp_q = eq;
    tbl.push_back(r);
  endtask

  task automatic send(input logic [63:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      sin = w[n-1-i];
      sin_valid = 1'b1;
      @(negedge clk);
    end
    sin_valid = 1'b0;
  endtask

  // ---------------- random reference model ----------------
  int          mn[2];
  logic [63:0] macc[2];
  bit          mheld[2];
  logic [63:0] mhw[2];
  bit          msv[2];
  logic [63:0] msd[2];
  logic [63:0] exp_c[$];
  logic [63:0] exp_d[$];

  function automatic int wof(input int k);
    return (k == 0) ? 5 : 13;
  endfunction

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      mn[k] = 0; macc[k] = '0; mheld[k] = 0; mhw[k] = '0; msv[k] = 0; msd[k] = '0;
    end
    exp_c.delete();
    exp_d.delete();
  endtask

  // One clock of behaviour: bits gathered into a word by position arithmetic.
  task automatic mstep(input int k, input bit v, input bit s, input bit f, input bit p);
    int w;
    bit free;
    logic [63:0] word;
    w = wof(k);
    free = !msv[k] || p;
    if (msv[k] && p) msv[k] = 0;
    if (f) begin
      mn[k] = 0; macc[k] = '0;
      if (mheld[k]) begin
        mheld[k] = 0;
        if (k == 0) void'(exp_c.pop_back()); else void'(exp_d.pop_back());
      end
    end else if (mheld[k]) begin
      if (free) begin
        msv[k] = 1; msd[k] = mhw[k]; mheld[k] = 0;
      end
    end else if (v) begin
      if (k == 0) macc[k] = (macc[k] << 1) | 64'(s);   // first bit ends at MSB
      else        macc[k] = macc[k] | (64'(s) << mn[k]); // first bit at bit 0
      mn[k]++;
      if (mn[k] == w) begin
        word = macc[k];
        if (k == 0) exp_c.push_back(word); else exp_d.push_back(word);
        mn[k] = 0; macc[k] = '0;
        if (free) begin
          msv[k] = 1; msd[k] = word;
        end else begin
          mheld[k] = 1; mhw[k] = word;
        end
      end
    end
  endtask

  task automatic mcheck(input int k, input logic pv, input logic [63:0] pd,
                        input int cnt, input logic rdy);
    string n;
    n = (k == 0) ? "w5" : "w13";
    chk({n, "_pvalid"}, 64'(pv), 64'(msv[k]));
    chk({n, "_count"}, 64'(cnt), 64'(mheld[k] ? wof(k) : mn[k]));
    chk({n, "_ready"}, 64'(rdy), 64'(!mheld[k]));
    chk({n, "_count_le_w"}, 64'(cnt <= wof(k)), 64'd1);
    if (msv[k]) chk({n, "_pdata"}, pd, msd[k]);
  endtask

  task automatic rand_cycle(input bit drain);
    mcheck(0, c_pvalid, 64'(c_pdata), int'(c_count), c_ready);
    mcheck(1, d_pvalid, 64'(d_pdata), int'(d_count), d_ready);
    rvalid  = drain ? 1'b0 : ($urandom_range(0, 3) != 0);
    rsin    = $urandom_range(0, 1) == 1;
    rflush  = drain ? 1'b0 : ($urandom_range(0, 49) == 0);
    rpready = drain ? 1'b1 : ($urandom_range(0, 1) == 1);
    if (c_pvalid && rpready) begin
      if (exp_c.size() == 0) chk("w5_duplicate_word", 64'd1, 64'd0);
      else chk("w5_word", 64'(c_pdata), exp_c.pop_front());
    end
    if (d_pvalid && rpready) begin
      if (exp_d.size() == 0) chk("w13_duplicate_word", 64'd1, 64'd0);
      else chk("w13_word", 64'(d_pdata), exp_d.pop_front());
    end
    mstep(0, rvalid, rsin, rflush, rpready);
    mstep(1, rvalid, rsin, rflush, rpready);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] wa, w5a;
    logic [4:0] c5;
    wa = 8'hB2; w5a = 8'h5A; c5 = 5'b11101;

    reset_b = 1'b0; sin = 1'b0; sin_valid = 1'b0; flush = 1'b0; pready = 1'b0;
    rsin = 1'b0; rvalid = 1'b0; rflush = 1'b0; rpready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_q", 64'(a_q), 64'd0);
    chk("rst_pdata", 64'(a_pdata), 64'd0);
    chk("rst_pvalid", 64'(a_pvalid), 64'd0);
    chk("rst_count", 64'(a_count), 64'd0);
    chk("rst_ready", 64'(a_ready), 64'd1);
    reset_b = 1'b1;

    // word B2 with consumer ready
    for (int i = 0; i < 8; i++)
      add(wa[7-i], 1, 0, 1, i == 7, (i == 7) ? 8'hB2 : 8'h00, (i == 7) ? 0 : i + 1, 1, i == 6, 8'h59);
    add(0, 0, 0, 1, 0, 8'hB2, 0, 1, 0, 8'h00);
    // B2 then FF with consumer stalled
    for (int i = 0; i < 8; i++)
      add(wa[7-i], 1, 0, 0, i == 7, 8'hB2, (i == 7) ? 0 : i + 1, 1, 0, 8'h00);
    for (int i = 0; i < 8; i++)
      add(1, 1, 0, 0, 1, 8'hB2, i + 1, i != 7, i == 7, 8'hFF);
    add(0, 1, 0, 0, 1, 8'hB2, 8, 0, 1, 8'hFF);
    add(0, 0, 0, 1, 1, 8'hFF, 0, 1, 0, 8'h00);
    add(0, 0, 0, 1, 0, 8'hFF, 0, 1, 0, 8'h00);
    // five bits, then flush with a sixth valid bit
    for (int i = 0; i < 5; i++)
      add(c5[4-i], 1, 0, 1, 0, 8'hFF, i + 1, 1, 0, 8'h00);
    add(1, 1, 1, 1, 0, 8'hFF, 0, 1, 1, 8'h00);
    // clean word after flush
    for (int i = 0; i < 8; i++)
      add(w5a[7-i], 1, 0, 0, i == 7, (i == 7) ? 8'h5A : 8'hFF, (i == 7) ? 0 : i + 1, 1, i == 6, 8'h2D);
    // flush leaves a pending output word alone, then handshake during flush
    for (int i = 0; i < 3; i++)
      add(1, 1, 0, 0, 1, 8'h5A, i + 1, 1, 0, 8'h00);
    add(1, 1, 1, 0, 1, 8'h5A, 0, 1, 1, 8'h00);
    add(0, 0, 1, 1, 0, 8'h5A, 0, 1, 0, 8'h00);

    for (int i = 0; i < tbl.size(); i++) begin
      sin = tbl[i].sin; sin_valid = tbl[i].vld; flush = tbl[i].fl; pready = tbl[i].pr;
      @(negedge clk);
      chk($sformatf("row%0d_pvalid", i), 64'(a_pvalid), 64'(tbl[i].exp_pv));
      chk($sformatf("row%0d_pdata", i), 64'(a_pdata), 64'(tbl[i].exp_pd));
      chk($sformatf("row%0d_count", i), 64'(a_count), 64'(tbl[i].exp_cnt));
      chk($sformatf("row%0d_ready", i), 64'(a_ready), 64'(tbl[i].exp_rdy));
      if (tbl[i].chk_q) chk($sformatf("row%0d_q", i), 64'(a_q), 64'(tbl[i].exp_q));
      if (i == 7) begin
        chk("lsb_first_pdata", 64'(b_pdata), 64'h4D);
        chk("lsb_first_pvalid", 64'(b_pvalid), 64'd1);
        chk("lsb_first_count", 64'(b_count), 64'd0);
      end
      if (i == 24) chk("lsb_first_ready_full", 64'(b_ready), 64'd0);
      if (i == 33) chk("lsb_first_q_flush", 64'(b_q), 64'd0);
    end
    sin_valid = 1'b0; flush = 1'b0; pready = 1'b0;

    // flush in FULL drops the parked word
    send(64'h3C, 8);
    chk("ff_first_pvalid", 64'(a_pvalid), 64'd1);
    chk("ff_first_pdata", 64'(a_pdata), 64'h3C);
    send(64'hC3, 8);
    chk("ff_full_count", 64'(a_count), 64'd8);
    chk("ff_full_ready", 64'(a_ready), 64'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("ff_flush_count", 64'(a_count), 64'd0);
    chk("ff_flush_ready", 64'(a_ready), 64'd1);
    chk("ff_flush_pdata", 64'(a_pdata), 64'h3C);
    chk("ff_flush_pvalid", 64'(a_pvalid), 64'd1);
    pready = 1'b1;
    @(negedge clk);
    chk("ff_take_pvalid", 64'(a_pvalid), 64'd0);
    @(negedge clk);
    chk("ff_no_late_word", 64'(a_pvalid), 64'd0);
    pready = 1'b0;

    // reset mid-frame with a pending word
    send(64'hA5, 8);
    send(64'h2D, 6);
    chk("rm_count_before", 64'(a_count), 64'd6);
    chk("rm_pvalid_before", 64'(a_pvalid), 64'd1);
    reset_b = 1'b0; sin = 1'b1; sin_valid = 1'b1; pready = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("rm_q", 64'(a_q), 64'd0);
    chk("rm_pdata", 64'(a_pdata), 64'd0);
    chk("rm_pvalid", 64'(a_pvalid), 64'd0);
    chk("rm_count", 64'(a_count), 64'd0);
    chk("rm_ready", 64'(a_ready), 64'd1);
    reset_b = 1'b1; sin_valid = 1'b0; pready = 1'b0; flush = 1'b0;
    @(negedge clk);

    // random streams at WIDTH=5 and WIDTH=13
    reset_b = 1'b0;
    @(negedge clk);
    reset_b = 1'b1;
    chk("w5_q_reset", 64'(c_q), 64'd0);
    chk("w13_q_reset", 64'(d_q), 64'd0);
    mreset();
    for (int n = 0; n < 3000; n++) rand_cycle(1'b0);
    for (int n = 0; n < 40; n++) rand_cycle(1'b1);
    chk("w5_lost_words", 64'(exp_c.size()), 64'd0);
    chk("w13_lost_words", 64'(exp_d.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sreg_deser.md
SREG_DESER -- requirements
Module: sreg_deser

Interface
REQ-001 Parameter WIDTH, default 8: word width in bits, legal range 2..64.
REQ-002 Parameter MSB_FIRST, default 1: 1 = first serial bit lands in q[WIDTH-1]; 0 = first serial bit lands in q[0].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_b  input  1  reset, synchronous and active-low.
REQ-005 sin  input  1  serial data bit.
REQ-006 sin_valid  input  1  sin qualifier.
REQ-007 sin_ready  output  1  block can accept a bit this cycle.
REQ-008 flush  input  1  synchronous abort of the partial frame.
REQ-009 q  output  WIDTH  live shift-register contents.
REQ-010 pdata  output  WIDTH  completed-word holding register.
REQ-011 pvalid  output  1  pdata holds an untaken word.
REQ-012 pready  input  1  consumer takes pdata when pvalid && pready.
REQ-013 count  output  $clog2(WIDTH+1)  bits currently held in the shift register.

Function
REQ-014 A bit is accepted on a cycle with sin_valid && sin_ready; no other cycle alters the shift register, except flush and the FULL transfer.
REQ-015 MSB_FIRST=1 accept: q <= {q[WIDTH-2:0], sin}. MSB_FIRST=0 accept: q <= {sin, q[WIDTH-1:1]}.
REQ-016 FSM states: EMPTY (count==0), ACCUM (0<count<WIDTH), FULL (count==WIDTH).
REQ-017 In EMPTY and ACCUM, sin_ready=1. In FULL, sin_ready=0.
REQ-018 Accept in EMPTY/ACCUM with count<WIDTH-1: count increments, and the state is EMPTY->ACCUM or stays ACCUM.
REQ-019 Accept with count==WIDTH-1 while the output slot is free (!pvalid, or pvalid && pready the same cycle): pdata <= shifted word, pvalid <= 1, count <= 0, state <= EMPTY.
REQ-020 Accept with count==WIDTH-1 while the slot is busy (pvalid && !pready): q <= shifted word, count <= WIDTH, state <= FULL.
REQ-021 FULL with slot free: pdata <= q, pvalid <= 1, count <= 0, state <= EMPTY; bits are accepted again on the following cycle.
REQ-022 Latency: pvalid and the new pdata are visible the cycle after the WIDTH-th accept (slot free), or the cycle after the slot frees (FULL).
REQ-023 pvalid clears the cycle after pvalid && pready, unless a new word loads the same cycle per REQ-019/021; back-to-back words lose no cycle.
REQ-024 pdata and pvalid are stable while pvalid && !pready.
REQ-025 flush: q <= 0, count <= 0, state <= EMPTY; a same-cycle accept is discarded, since flush wins.
REQ-026 flush does not affect pdata or pvalid; a same-cycle pready handshake still completes.
REQ-027 flush in FULL discards the held word, and no pvalid is raised for it.
REQ-028 sin is ignored when sin_valid=0 or sin_ready=0.

Reset
REQ-029 reset_b=0 at a clock edge: q=0, pdata=0, pvalid=0, count=0, state=EMPTY, sin_ready=1 from the next cycle.
REQ-030 Reset overrides flush and all handshakes; reset mid-frame or in FULL discards all data.

Structure
REQ-031 A shared package sreg_pkg holds the state enum (EMPTY, ACCUM, FULL) and a function returning the count width for a given WIDTH.
REQ-032 One sub-module, sreg_core (WIDTH, MSB_FIRST; ports en, sin, clr, load, d, q), implements the shift/clear/load register; sreg_deser contains the FSM, counter and output slot.

Verification
REQ-033 WIDTH=8, MSB_FIRST=1; bits 1,0,1,1,0,0,1,0 on consecutive cycles with pready=1 -> pdata=8'hB2, pvalid high for 1 cycle, one cycle after the 8th bit.
REQ-034 MSB_FIRST=0, same bit sequence -> pdata=8'h4D.
REQ-035 pready=0; stream 16 bits (word A=8'hB2, then word B=8'hFF) -> sin_ready drops after B's 8th bit and pdata stays 8'hB2. Then pready=1 for 1 cycle -> pdata=8'hFF next cycle, sin_ready=1 again.
REQ-036 Send 5 bits, assert flush together with a 6th valid bit -> count=0, q=0, pvalid unchanged; the next 8 bits form a clean word.
REQ-037 Pulse reset_b=0 with count=6 and pvalid=1 -> all outputs zero the next cycle, sin_ready=1.
REQ-038 Continuous random stream at WIDTH=5 and WIDTH=13, pready toggling randomly -> scoreboard shows no lost or duplicated word, and count never exceeds WIDTH.
